// File: rtl/arb_2x1_if.sv
// Handshake bundle for the 2:1 round-robin arbiter: two producer channels in, one consumer channel out.
interface arb_2x1_if #(
    parameter int unsigned WIDTH = 8
);
    logic             a1_valid;
    logic [WIDTH-1:0] a1_data;
    logic             a1_ready;
    logic             a2_valid;
    logic [WIDTH-1:0] a2_data;
    logic             a2_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport slave (
        input  a1_valid, a1_data, a2_valid, a2_data, out_ready,
        output a1_ready, a2_ready, out_valid, out_data
    );

    modport master (
        output a1_valid, a1_data, a2_valid, a2_data, out_ready,
        input  a1_ready, a2_ready, out_valid, out_data
    );
endinterface

// File: rtl/arb_2x1.sv
// 2:1 round-robin arbiter feeding a single registered output stage (EMPTY/FULL),
// with a wrapping count of words delivered downstream.
module arb_2x1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    arb_2x1_if.slave       bus,
    output logic           s,
    output logic [15:0]    xfer_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] data_q;
    logic             last1_q;
    logic             load_ok;
    logic             grant1;
    logic             grant2;
    logic             take1;
    logic             take2;
    logic             deliver;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (take1 || take2) state_next = FULL;
            FULL:  if (bus.out_ready && !(take1 || take2)) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Readies are gated by rst_n so nothing is offered while reset is asserted.
    always_comb begin
        load_ok      = (state == EMPTY) || bus.out_ready;
        grant1       = bus.a1_valid && (!bus.a2_valid || !last1_q);
        grant2       = bus.a2_valid && (!bus.a1_valid ||  last1_q);
        bus.a1_ready = rst_n && load_ok && grant1;
        bus.a2_ready = rst_n && load_ok && grant2;
        take1        = bus.a1_ready;
        take2        = bus.a2_ready;
        deliver      = (state == FULL) && bus.out_ready;
        bus.out_valid = (state == FULL);
        bus.out_data  = data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            s       <= 1'b0;
            last1_q <= 1'b0;
        end else if (take1) begin
            data_q  <= bus.a1_data;
            s       <= 1'b1;
            last1_q <= 1'b1;
        end else if (take2) begin
            data_q  <= bus.a2_data;
            s       <= 1'b0;
            last1_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       xfer_cnt <= '0;
        else if (deliver) xfer_cnt <= xfer_cnt + 16'd1;
    end
endmodule

// File: tb/tb_arb_2x1.sv
// Scoreboard bench for arb_2x1: a reference model predicts grants and pushes expected
// {s,data} words on accept; words are popped and compared as the DUT delivers them.
module tb_arb_2x1;
    localparam int unsigned WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s;
    logic [15:0] xfer_cnt;

    arb_2x1_if #(.WIDTH(WIDTH)) bus();

    arb_2x1 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .s        (s),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [8:0]  sb_q[$];
    logic        m_valid;
    logic        m_s;
    logic        m_last1;
    logic [7:0]  m_data;
    logic [15:0] m_cnt;
    bit          sb_on;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_s     = 1'b0;
        m_last1 = 1'b0;
        m_data  = '0;
        m_cnt   = '0;
        sb_q.delete();
    endtask

    // One clock: predict and compare at the falling edge, then return just after the rising edge.
    task automatic step();
        logic       load_ok, g1, g2, r1, r2;
        logic [8:0] w;
        @(negedge clk);
        load_ok = !m_valid || bus.out_ready;
        g1 = bus.a1_valid && (!bus.a2_valid || !m_last1);
        g2 = bus.a2_valid && (!bus.a1_valid ||  m_last1);
        r1 = load_ok && g1;
        r2 = load_ok && g2;
        if (sb_on) begin
            check("a1_ready", bus.a1_ready, r1);
            check("a2_ready", bus.a2_ready, r2);
            check("out_valid", bus.out_valid, m_valid);
            check("out_data", bus.out_data, m_data);
            check("s", s, m_s);
            check("xfer_cnt", xfer_cnt, m_cnt);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (sb_on) check("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                w = sb_q.pop_front();
                if (sb_on) check("sb_word", {s, bus.out_data}, w);
            end
        end
        if (m_valid && bus.out_ready) m_cnt++;
        if (r1) begin
            m_data = bus.a1_data; m_s = 1'b1; m_valid = 1'b1; m_last1 = 1'b1;
            sb_q.push_back({1'b1, bus.a1_data});
        end else if (r2) begin
            m_data = bus.a2_data; m_s = 1'b0; m_valid = 1'b1; m_last1 = 1'b0;
            sb_q.push_back({1'b0, bus.a2_data});
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; pulses reset between edges and checks its asynchronous effect.
    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_s", s, 0);
        check("rst_xfer_cnt", xfer_cnt, 0);
        check("rst_a1_ready", bus.a1_ready, 0);
        check("rst_a2_ready", bus.a2_ready, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.a1_valid  = 1'b1;
        bus.a1_data   = 8'h11;
        bus.a2_valid  = 1'b0;
        bus.a2_data   = '0;
        bus.out_ready = 1'b1;
        sb_on         = 1'b1;
        model_reset();

        #2;
        check("init_a1_ready", bus.a1_ready, 0);
        check("init_a2_ready", bus.a2_ready, 0);
        check("init_out_valid", bus.out_valid, 0);
        check("init_xfer_cnt", xfer_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word on channel 1, one-cycle latency.
        step();
        check("first_out_valid", bus.out_valid, 1);
        check("first_out_data", bus.out_data, 8'h11);
        check("first_s", s, 1);
        bus.a1_valid = 1'b0;
        step();
        step();

        // Round-robin with both channels valid continuously.
        async_reset();
        bus.a1_valid = 1'b1; bus.a1_data = 8'hA1;
        bus.a2_valid = 1'b1; bus.a2_data = 8'hA2;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_data", bus.out_data, (i % 2 == 0) ? 8'hA1 : 8'hA2);
            check("rr_s", s, (i % 2 == 0) ? 1 : 0);
            check("rr_valid", bus.out_valid, 1);
        end
        bus.a1_valid = 1'b0;
        bus.a2_valid = 1'b0;
        step();
        check("rr_xfer_cnt_4", xfer_cnt, 4);

        // Stall on channel 2, with a transient channel-1 valid that must not be taken.
        bus.a2_valid = 1'b1; bus.a2_data = 8'h5C;
        bus.out_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin bus.a1_valid = 1'b1; bus.a1_data = 8'hEE; end
            else bus.a1_valid = 1'b0;
            step();
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, 8'h5C);
        end
        bus.a1_valid = 1'b0;
        bus.a2_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("stall_drained", bus.out_valid, 0);
        step();

        // Drain with no new input: s keeps its channel-1 value.
        bus.a1_valid = 1'b1; bus.a1_data = 8'h3C;
        step();
        bus.a1_valid = 1'b0;
        step();
        check("drain_valid", bus.out_valid, 0);
        check("drain_s_hold", s, 1);
        check("drain_data_hold", bus.out_data, 8'h3C);

        // Reset in the middle of a stall, then a tie must go to channel 1.
        bus.a2_valid = 1'b1; bus.a2_data = 8'h77;
        bus.out_ready = 1'b0;
        step();
        step();
        check("pre_rst_full", bus.out_valid, 1);
        async_reset();
        bus.a1_valid = 1'b1; bus.a1_data = 8'h12;
        bus.a2_valid = 1'b1; bus.a2_data = 8'h34;
        bus.out_ready = 1'b1;
        step();
        check("post_rst_tie_s", s, 1);
        check("post_rst_tie_data", bus.out_data, 8'h12);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            bus.a1_valid  = 1'($urandom_range(0, 1));
            bus.a2_valid  = 1'($urandom_range(0, 1));
            bus.a1_data   = 8'($urandom);
            bus.a2_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.a1_valid = 1'b0;
        bus.a2_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("sb_empty", sb_q.size(), 0);

        // Counter wrap: 65535 deliveries reach FFFF, one more wraps to 0.
        async_reset();
        sb_on = 1'b0;
        bus.a1_valid = 1'b1; bus.a1_data = 8'h99;
        bus.out_ready = 1'b1;
        repeat (65536) step();
        check("cnt_ffff", xfer_cnt, 16'hFFFF);
        check("cnt_model_ffff", xfer_cnt, m_cnt);
        sb_on = 1'b1;
        bus.a1_valid = 1'b0;
        step();
        check("cnt_wrap", xfer_cnt, 0);
        check("cnt_wrap_valid", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
